// File: rtl/zeroriscy_load_store_unit.sv
// Load/store unit: turns an effective address from the EX adder into one or two
// word-aligned data-bus transactions and returns aligned, extended load data.
module zeroriscy_load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_ex_i,
  input  logic        data_we_ex_i,
  input  logic [1:0]  data_type_ex_i,
  input  logic        data_sign_ext_ex_i,
  input  logic [31:0] data_wdata_ex_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] data_rdata_ex_o,
  output logic        lsu_ready_ex_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_GNT0 = 3'd1,
    WAIT_RV0  = 3'd2,
    WAIT_GNT1 = 3'd3,
    WAIT_RV1  = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] rdata_q;     // beat-0 read data of a misaligned load
  logic        orphan_q;    // set by reset until the first new grant: a late response may still arrive

  logic [1:0]  off;
  logic        misaligned;
  logic        beat1;
  logic        req;
  logic        complete;
  logic        capture;
  logic [3:0]  be0;
  logic [3:0]  be1;
  logic [63:0] rdata_wide;
  logic [63:0] rdata_shift;
  logic [31:0] rdata_aligned;
  logic [31:0] rdata_ext;

  assign off   = adder_result_ex_i[1:0];
  assign beat1 = (state_q == WAIT_GNT1) || (state_q == WAIT_RV1);

  // Misalignment: access spans two bus words
  always_comb begin
    misaligned = 1'b0;
    case (data_type_ex_i)
      2'b01:   misaligned = (off == 2'd3);
      2'b10:   misaligned = 1'b0;
      default: misaligned = (off != 2'd0);
    endcase
  end

  // Byte enables for the first and (if needed) second beat
  always_comb begin
    be0 = 4'b1111;
    be1 = 4'b0000;
    case (data_type_ex_i)
      2'b01: begin
        case (off)
          2'd0:    be0 = 4'b0011;
          2'd1:    be0 = 4'b0110;
          2'd2:    be0 = 4'b1100;
          default: begin be0 = 4'b1000; be1 = 4'b0001; end
        endcase
      end
      2'b10: be0 = 4'b0001 << off;
      default: begin
        case (off)
          2'd0:    be0 = 4'b1111;
          2'd1:    begin be0 = 4'b1110; be1 = 4'b0001; end
          2'd2:    begin be0 = 4'b1100; be1 = 4'b0011; end
          default: begin be0 = 4'b1000; be1 = 4'b0111; end
        endcase
      end
    endcase
  end

  // Store data rotated so each byte lands on its lane; same value on both beats
  always_comb begin
    data_wdata_o = data_wdata_ex_i;
    case (off)
      2'd1:    data_wdata_o = {data_wdata_ex_i[23:0], data_wdata_ex_i[31:24]};
      2'd2:    data_wdata_o = {data_wdata_ex_i[15:0], data_wdata_ex_i[31:16]};
      2'd3:    data_wdata_o = {data_wdata_ex_i[7:0],  data_wdata_ex_i[31:8]};
      default: data_wdata_o = data_wdata_ex_i;
    endcase
  end

  assign data_be_o   = beat1 ? be1 : be0;
  assign data_addr_o = {adder_result_ex_i[31:2] + {29'd0, beat1}, 2'b00};
  assign data_we_o   = data_we_ex_i;

  // Load alignment: second beat supplies the upper bytes above rdata_q
  assign rdata_wide    = beat1 ? {data_rdata_i, rdata_q} : {32'd0, data_rdata_i};
  assign rdata_shift   = rdata_wide >> {off, 3'b000};
  assign rdata_aligned = rdata_shift[31:0];

  // Truncate to access size and extend
  always_comb begin
    rdata_ext = rdata_aligned;
    case (data_type_ex_i)
      2'b01:   rdata_ext = {{16{data_sign_ext_ex_i & rdata_aligned[15]}}, rdata_aligned[15:0]};
      2'b10:   rdata_ext = {{24{data_sign_ext_ex_i & rdata_aligned[7]}},  rdata_aligned[7:0]};
      default: rdata_ext = rdata_aligned;
    endcase
  end

  // Next-state and handshake decode
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    complete = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        req = data_req_ex_i;
        if (data_req_ex_i) begin
          state_d = data_gnt_i ? WAIT_RV0 : WAIT_GNT0;
        end
      end
      WAIT_GNT0: begin
        req = 1'b1;
        if (data_gnt_i) state_d = WAIT_RV0;
      end
      WAIT_RV0: begin
        if (data_rvalid_i) begin
          if (data_err_i || !misaligned) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            capture = 1'b1;
            state_d = WAIT_GNT1;
          end
        end
      end
      WAIT_GNT1: begin
        req = 1'b1;
        if (data_gnt_i) state_d = WAIT_RV1;
      end
      WAIT_RV1: begin
        if (data_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request is forced low while reset is held, even if ID keeps requesting
  assign data_req_o      = req & rst_n;
  assign lsu_ready_ex_o  = complete | ((state_q == IDLE) & ~data_req_ex_i);
  assign load_err_o      = complete & data_err_i & ~data_we_ex_i;
  assign store_err_o     = complete & data_err_i & data_we_ex_i;
  assign data_rdata_ex_o = (complete && !data_we_ex_i) ? rdata_ext : 32'd0;
  assign busy_o          = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Hold beat-0 read data for the second half of a misaligned load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rdata_q <= 32'd0;
    else if (capture) rdata_q <= data_rdata_i;
  end

  // Track whether a response from before reset could still be in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        orphan_q <= 1'b1;
    else if (data_req_o && data_gnt_i) orphan_q <= 1'b0;
  end

  // A response outside a response-wait state is a protocol violation
  assert property (@(posedge clk) disable iff (!rst_n)
    !(data_rvalid_i && !orphan_q && (state_q != WAIT_RV0) && (state_q != WAIT_RV1)));

endmodule
